// File: rtl/adc_pkg.sv
// Shared types and frame geometry for the ADC SPI reader.
// The 16-bit frame carries 4 leading zero bits followed by 12 data bits.
package adc_pkg;

   localparam int FrameBits = 16;
   localparam int DataBits  = 12;
   localparam int LeadBits  = 4;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t SETUP = 3'd1;
   localparam state_t SHIFT = 3'd2;
   localparam state_t DONE  = 3'd3;
   localparam state_t QUIET = 3'd4;

endpackage

// File: rtl/adc_spi_reader_if.sv
// Serial pins between the reader (master) and the ADC (slave).
interface adc_spi_reader_if;

   logic adc_cs_no;
   logic adc_sclk_o;
   logic adc_sdata_i;

   modport master (output adc_cs_no, output adc_sclk_o, input adc_sdata_i);
   modport slave  (input adc_cs_no, input adc_sclk_o, output adc_sdata_i);

endinterface

// File: rtl/adc_sclk_div.sv
// Half-period tick generator: tick_o is high on every ClkDiv-th cycle after clr_i drops.
module adc_sclk_div #(
   parameter int unsigned ClkDiv = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tick_o
);

   localparam logic [3:0] Last = 4'(ClkDiv - 1);

   logic [3:0] cnt_q;

   assign tick_o = (cnt_q == Last);

   // Counter restarts on the tick itself, so it never wraps past Last.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i || tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

endmodule

// File: rtl/adc_spi_reader.sv
// Reads one 16-bit frame from an SPI ADC per trigger (CPOL=1, capture on SCLK rise).
// All outputs come straight from flops; the frame FSM owns the shift and output registers.
module adc_spi_reader
   import adc_pkg::*;
#(
   parameter int unsigned ClkDiv      = 2,
   parameter int unsigned QuietCycles = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                trigger_i,
   output logic                eoc_o,
   output logic [DataBits-1:0] data_o,
   output logic                frame_err_o,
   output logic                busy_o,
   output logic                overrun_o,
   adc_spi_reader_if.master    spi
);

   state_t               state_q;
   logic                 cs_n_q;
   logic                 sclk_q;
   logic [FrameBits-1:0] frame_q;
   logic [3:0]           bit_cnt_q;
   logic [7:0]           quiet_cnt_q;
   logic                 tick;

   assign spi.adc_cs_no  = cs_n_q;
   assign spi.adc_sclk_o = sclk_q;

   adc_sclk_div #(.ClkDiv(ClkDiv)) u_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (!(state_q == SETUP || state_q == SHIFT)),
      .tick_o (tick)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b1;
         busy_o      <= 1'b0;
         eoc_o       <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         data_o      <= '0;
         frame_q     <= '0;
         bit_cnt_q   <= '0;
         quiet_cnt_q <= '0;
      end else begin
         eoc_o       <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= trigger_i && (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (trigger_i) begin
                  state_q   <= SETUP;
                  cs_n_q    <= 1'b0;
                  busy_o    <= 1'b1;
                  bit_cnt_q <= '0;
                  frame_q   <= '0;
               end
            end
            SETUP: begin
               if (tick) begin
                  state_q <= SHIFT;
                  sclk_q  <= 1'b0;
               end
            end
            SHIFT: begin
               // Low half ends with the rising edge and the capture; high half ends the bit.
               if (tick) begin
                  if (!sclk_q) begin
                     sclk_q  <= 1'b1;
                     frame_q <= {frame_q[FrameBits-2:0], spi.adc_sdata_i};
                  end else if (bit_cnt_q == 4'(FrameBits - 1)) begin
                     state_q     <= DONE;
                     cs_n_q      <= 1'b1;
                     eoc_o       <= 1'b1;
                     data_o      <= frame_q[DataBits-1:0];
                     frame_err_o <= |frame_q[FrameBits-1 -: LeadBits];
                     quiet_cnt_q <= '0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     sclk_q    <= 1'b0;
                  end
               end
            end
            DONE: begin
               state_q <= QUIET;
            end
            QUIET: begin
               if (quiet_cnt_q == 8'(QuietCycles - 1)) begin
                  state_q <= IDLE;
                  busy_o  <= 1'b0;
               end else begin
                  quiet_cnt_q <= quiet_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               cs_n_q  <= 1'b1;
               sclk_q  <= 1'b1;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: frame-level timing model, table vectors, corner sequences, random triggers.
module tb_adc_spi_reader;
   import adc_pkg::*;

   localparam int D   = 2;
   localparam int Q   = 4;
   localparam int LAT = 1 + 33 * D;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic trig_a = 1'b0, trig_b = 1'b0;
   logic eoc_a, err_a, busy_a, ovr_a;
   logic eoc_b, err_b, busy_b, ovr_b;
   logic [11:0] data_a, data_b;

   adc_spi_reader_if spi_a ();
   adc_spi_reader_if spi_b ();

   adc_spi_reader #(.ClkDiv(D), .QuietCycles(Q)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig_a), .eoc_o(eoc_a), .data_o(data_a),
      .frame_err_o(err_a), .busy_o(busy_a), .overrun_o(ovr_a), .spi(spi_a.master));

   adc_spi_reader #(.ClkDiv(1), .QuietCycles(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig_b), .eoc_o(eoc_b), .data_o(data_b),
      .frame_err_o(err_b), .busy_o(busy_b), .overrun_o(ovr_b), .spi(spi_b.master));

   always #5 clk = ~clk;

   // ADC models: present bit 15 at CS fall, advance one bit after each SCLK rise.
   logic [15:0] word_a = 16'h0, word_b = 16'h0123;
   int idx_a = 15, idx_b = 15;
   always @(negedge spi_a.adc_cs_no) idx_a = 15;
   always @(posedge spi_a.adc_sclk_o) if (!spi_a.adc_cs_no) idx_a = idx_a - 1;
   always @(negedge spi_b.adc_cs_no) idx_b = 15;
   always @(posedge spi_b.adc_sclk_o) if (!spi_b.adc_cs_no) idx_b = idx_b - 1;
   assign spi_a.adc_sdata_i = (idx_a >= 0) ? word_a[idx_a[3:0]] : 1'b0;
   assign spi_b.adc_sdata_i = (idx_b >= 0) ? word_b[idx_b[3:0]] : 1'b0;

   int checks = 0, errors = 0;
   int cyc = 0;

   // Frame model: a frame is the trigger cycle m_t plus its word; everything else follows by arithmetic.
   int          m_t = -1000;
   logic [15:0] m_word = 16'h0;
   logic [11:0] m_hold = 12'h0;
   logic        exp_ovr = 1'b0;

   function automatic bit m_busy(input int n);
      return (n >= m_t + 1) && (n <= m_t + LAT + Q);
   endfunction

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d: got %0b want %0b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_d(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d: got %03h want %03h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc %0d: got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_cycle();
      int  e, o;
      bit  shifting;
      e = m_t + LAT;
      o = cyc - (m_t + 1 + D);
      shifting = (cyc >= m_t + 1 + D) && (cyc <= e - 1);
      chk_b("eoc", eoc_a, cyc == e);
      chk_b("frame_err", err_a, (cyc == e) && (|m_word[15:12]));
      chk_d("data", data_a, (cyc >= e) ? m_word[11:0] : m_hold);
      chk_b("busy", busy_a, m_busy(cyc));
      chk_b("overrun", ovr_a, exp_ovr);
      chk_b("cs_n", spi_a.adc_cs_no, !((cyc >= m_t + 1) && (cyc <= e - 1)));
      chk_b("sclk", spi_a.adc_sclk_o, shifting ? ((o / D) % 2 == 1) : 1'b1);
   endtask

   // One clock: trig is high during the current cycle, outputs checked in the next one.
   task automatic step(input logic trig, input logic [15:0] word);
      logic exp_next;
      exp_next = trig && m_busy(cyc);
      if (trig && !m_busy(cyc)) begin
         m_hold = m_word[11:0];
         m_word = word;
         m_t    = cyc;
         word_a = word;
      end
      trig_a = trig;
      @(posedge clk);
      #1;
      cyc++;
      exp_ovr = exp_next;
      trig_a  = 1'b0;
      check_cycle();
   endtask

   task automatic wait_eoc(output int at);
      at = -1;
      for (int k = 0; k < 300 && at < 0; k++) begin
         step(1'b0, 16'h0);
         if (eoc_a) at = cyc;
      end
   endtask

   typedef struct {
      logic [15:0] word;
      logic [11:0] data;
      logic        err;
   } vec_t;

   vec_t vec[7];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int at, t0, n_eoc;
      int eq[$];
      int rq[$];
      logic prev_sclk_b;
      logic [15:0] w;

      vec[0] = '{16'h0A5C, 12'hA5C, 1'b0};
      vec[1] = '{16'h8FFF, 12'hFFF, 1'b1};
      vec[2] = '{16'h0000, 12'h000, 1'b0};
      vec[3] = '{16'hF000, 12'h000, 1'b1};
      vec[4] = '{16'h1001, 12'h001, 1'b1};
      vec[5] = '{16'h0FFF, 12'hFFF, 1'b0};
      vec[6] = '{16'h4321, 12'h321, 1'b1};

      #1 rst_n = 1'b0;
      #20;
      chk_b("rst_cs_n", spi_a.adc_cs_no, 1'b1);
      chk_b("rst_sclk", spi_a.adc_sclk_o, 1'b1);
      chk_b("rst_eoc", eoc_a, 1'b0);
      chk_b("rst_err", err_a, 1'b0);
      chk_b("rst_busy", busy_a, 1'b0);
      chk_b("rst_overrun", ovr_a, 1'b0);
      chk_d("rst_data", data_a, 12'h000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      check_cycle();

      // Trigger in cycle 10 -> CS low in 11, EOC in 77.
      repeat (10) step(1'b0, 16'h0);
      step(1'b1, 16'h0A5C);
      chk_b("cs_low_at_11", spi_a.adc_cs_no, 1'b0);
      wait_eoc(at);
      chk_i("eoc_at_77", at, 77);
      chk_d("first_data", data_a, 12'hA5C);
      chk_b("first_err", err_a, 1'b0);

      for (int i = 0; i < 7; i++) begin
         repeat (Q + 1) step(1'b0, 16'h0);
         t0 = cyc;
         step(1'b1, vec[i].word);
         wait_eoc(at);
         chk_i("tbl_latency", at - t0, LAT);
         chk_d("tbl_data", data_a, vec[i].data);
         chk_b("tbl_err", err_a, vec[i].err);
      end

      // Second trigger 20 cycles into a frame.
      repeat (Q + 1) step(1'b0, 16'h0);
      t0 = cyc;
      step(1'b1, 16'h0C96);
      repeat (19) step(1'b0, 16'h0);
      step(1'b1, 16'hFFFF);
      chk_b("ovr_mid_frame", ovr_a, 1'b1);
      n_eoc = 0;
      for (int k = 0; k < 150; k++) begin
         step(1'b0, 16'h0);
         if (eoc_a) begin
            n_eoc++;
            chk_d("ovr_frame_data", data_a, 12'hC96);
            chk_i("ovr_frame_latency", cyc - t0, LAT);
         end
      end
      chk_i("ovr_eoc_count", n_eoc, 1);

      // Trigger on last QUIET cycle, then on first IDLE cycle.
      t0 = cyc;
      step(1'b1, 16'h0ABC);
      wait_eoc(at);
      repeat (Q) step(1'b0, 16'h0);
      step(1'b1, 16'h0111);
      chk_b("last_quiet_ovr", ovr_a, 1'b1);
      chk_b("last_quiet_idle", busy_a, 1'b0);
      t0 = cyc;
      step(1'b1, 16'h0777);
      chk_b("first_idle_cs", spi_a.adc_cs_no, 1'b0);
      chk_b("first_idle_busy", busy_a, 1'b1);
      wait_eoc(at);
      chk_i("first_idle_latency", at - t0, LAT);
      chk_d("first_idle_data", data_a, 12'h777);

      // Reset during SHIFT bit 7 (low half), data register holds 0x777 before it.
      repeat (Q + 1) step(1'b0, 16'h0);
      t0 = cyc;
      step(1'b1, 16'h0ABC);
      while (cyc < t0 + 3 + 4 * 7) step(1'b0, 16'h0);
      chk_b("pre_rst_sclk_low", spi_a.adc_sclk_o, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_b("mid_rst_cs_n", spi_a.adc_cs_no, 1'b1);
      chk_b("mid_rst_sclk", spi_a.adc_sclk_o, 1'b1);
      chk_d("mid_rst_data", data_a, 12'h000);
      chk_b("mid_rst_eoc", eoc_a, 1'b0);
      chk_b("mid_rst_busy", busy_a, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
      rst_n   = 1'b1;
      m_t     = -1000;
      m_word  = 16'h0;
      m_hold  = 12'h0;
      exp_ovr = 1'b0;
      check_cycle();
      repeat (5) step(1'b0, 16'h0);
      t0 = cyc;
      step(1'b1, 16'h0456);
      wait_eoc(at);
      chk_i("post_rst_latency", at - t0, LAT);
      chk_d("post_rst_data", data_a, 12'h456);

      // Random triggers against the frame model.
      for (int k = 0; k < 600; k++) begin
         w = 16'($urandom);
         step($urandom_range(0, 15) == 0, w);
      end
      repeat (LAT + Q + 2) step(1'b0, 16'h0);

      // ClkDiv=1, QuietCycles=1 with trigger held high.
      t0 = cyc;
      trig_b = 1'b1;
      prev_sclk_b = 1'b1;
      for (int k = 0; k < 120; k++) begin
         step(1'b0, 16'h0);
         if (eoc_b) begin
            eq.push_back(cyc);
            chk_d("b_data", data_b, 12'h123);
            chk_b("b_err", err_b, 1'b0);
            chk_b("b_busy_at_eoc", busy_b, 1'b1);
         end
         if (eq.size() == 1 && cyc == eq[0] + 1) chk_b("b_overrun_held", ovr_b, 1'b1);
         if (eq.size() == 0 && spi_b.adc_sclk_o && !prev_sclk_b) rq.push_back(cyc);
         prev_sclk_b = spi_b.adc_sclk_o;
      end
      trig_b = 1'b0;
      chk_i("b_eoc_count", eq.size(), 3);
      chk_i("b_first_latency", (eq.size() > 0) ? eq[0] - t0 : -1, 34);
      chk_i("b_spacing_1", (eq.size() > 1) ? eq[1] - eq[0] : -1, 36);
      chk_i("b_spacing_2", (eq.size() > 2) ? eq[2] - eq[1] : -1, 36);
      chk_i("b_sclk_rises", rq.size(), 16);
      chk_i("b_sclk_period_first", (rq.size() > 1) ? rq[1] - rq[0] : -1, 2);
      chk_i("b_sclk_period_last", (rq.size() > 15) ? rq[15] - rq[14] : -1, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
